// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front end: operation codes,
// sequencer states and the execute-fault rule.
package calc_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_MUL = 4'b0010,
        OP_DIV = 4'b0011,
        OP_MOD = 4'b0100,
        OP_AND = 4'b0101,
        OP_OR  = 4'b0110,
        OP_XOR = 4'b0111,
        OP_SHL = 4'b1000,
        OP_SHR = 4'b1001
    } op_t;

    localparam logic [OP_W-1:0] OP_LAST = 4'b1001;

    typedef enum logic [STATE_W-1:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } seq_state_t;

    // Division/modulo by zero and codes past OP_LAST have no defined result.
    function automatic logic op_faults(input logic [OP_W-1:0] op, input logic divisor_zero);
        return ((op == OP_DIV || op == OP_MOD) && divisor_zero) || (op > OP_LAST);
    endfunction

endpackage

// File: rtl/calc_operand_sequencer_enter_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for a raw push button;
// emits one registered single-cycle pulse per press.
module enter_sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic i_button,
    output logic o_pulse
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_sync2_d;
    logic [1:0] r_fill;
    logic       r_armed;
    logic       r_pulse;

    // A button held through reset must not count as a press: edges are only
    // armed once a genuine low sample has passed through the synchronizer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync2_d <= 1'b0;
            r_fill    <= '0;
            r_armed   <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_sync1   <= i_button;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
            r_fill    <= {r_fill[0], 1'b1};
            r_armed   <= r_armed | (r_fill[1] & ~r_sync2);
            r_pulse   <= r_sync2 & ~r_sync2_d & r_armed;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/calc_operand_sequencer.sv
// Collects operand1, operand2 and an op code through one enter button, drives
// the combinational calculator and holds its result with valid/error flags.
module calc_operand_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned Nbits = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [Nbits-1:0]     data_in,
    input  logic [OP_W-1:0]      op_in,
    input  logic                 enter,
    input  logic                 clear,
    output logic [OP_W-1:0]      op_select,
    output logic [Nbits-1:0]     operand1,
    output logic [Nbits-1:0]     operand2,
    input  logic [2*Nbits-1:0]   resultado_in,
    output logic [2*Nbits-1:0]   result_q,
    output logic                 result_valid,
    output logic                 err,
    output logic [STATE_W-1:0]   state_code
);

    seq_state_t           r_state;
    logic [OP_W-1:0]      r_op_select;
    logic [Nbits-1:0]     r_operand1;
    logic [Nbits-1:0]     r_operand2;
    logic [2*Nbits-1:0]   r_result;
    logic                 r_valid;
    logic                 r_err;

    logic                 w_enter_p;
    logic                 w_exec_fault;

    enter_sync_edge u_enter_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_button (enter),
        .o_pulse  (w_enter_p)
    );

    assign w_exec_fault = op_faults(r_op_select, r_operand2 == '0);

    // clear outranks everything, so an enter pulse in the same cycle is lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_A;
            r_op_select <= '0;
            r_operand1  <= '0;
            r_operand2  <= '0;
            r_result    <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
        end else if (clear) begin
            r_state     <= S_A;
            r_op_select <= '0;
            r_operand1  <= '0;
            r_operand2  <= '0;
            r_result    <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_A: begin
                    if (w_enter_p) begin
                        r_operand1 <= data_in;
                        r_valid    <= 1'b0;
                        r_err      <= 1'b0;
                        r_state    <= S_B;
                    end
                end
                S_B: begin
                    if (w_enter_p) begin
                        r_operand2 <= data_in;
                        r_state    <= S_OP;
                    end
                end
                S_OP: begin
                    if (w_enter_p) begin
                        r_op_select <= op_in;
                        r_state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result <= w_exec_fault ? '0 : resultado_in;
                    r_valid  <= 1'b1;
                    r_err    <= w_exec_fault;
                    r_state  <= S_SHOW;
                end
                S_SHOW: begin
                    if (w_enter_p) begin
                        r_state <= S_A;
                    end
                end
                default: r_state <= S_A;
            endcase
        end
    end

    assign op_select    = r_op_select;
    assign operand1     = r_operand1;
    assign operand2     = r_operand2;
    assign result_q     = r_result;
    assign result_valid = r_valid;
    assign err          = r_err;
    assign state_code   = r_state;

endmodule

// File: doc/calc_operand_sequencer.md
# calc_operand_sequencer

Sequential front end that sits directly upstream of the combinational calculator. It collects two operands and an operation code from board switches through a single `enter` button, drives the calculator's `op_select`/`operand1`/`operand2` inputs, and registers the calculator's `resultado` into a held result with a valid flag and an error flag. It is the only clocked stage between the user inputs and the ALU.

## Interface
- `Nbits`, default 4: operand width. The result width is 2·Nbits.
- `clock`  in  1: single system clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `data_in`  in  Nbits: operand switches; asynchronous to `clock`, but static while `enter` is pressed.
- `op_in`  in  4: operation-code switches.
- `enter`  in  1: raw button, asynchronous, active-high.
- `clear`  in  1: synchronous, active-high abort/clear, already in the `clock` domain.
- `op_select`  out  4: to calculator.
- `operand1`  out  Nbits: to calculator.
- `operand2`  out  Nbits: to calculator.
- `resultado_in`  in  2·Nbits: from calculator `resultado`.
- `result_q`  out  2·Nbits: registered, held result.
- `result_valid`  out  1: `result_q` holds the result of the current operand set.
- `err`  out  1: last execution was division or modulo by zero, or used an unsupported op code.
- `state_code`  out  3: current FSM state encoding, for LEDs.

## Operation
- Operation codes: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 MOD, 0101 AND, 0110 OR, 0111 XOR, 1000 SHL, 1001 SHR. Codes 1010–1111 are unsupported.
- Enter pulse: `enter` passes through a two-flop synchronizer followed by rising-edge detection. This yields exactly one `enter_p` pulse per press, however long the button is held.
- FSM states and encodings: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.
- S_A, on `enter_p`: `operand1` ← `data_in`; clear `result_valid` and `err`; go to S_B.
- S_B, on `enter_p`: `operand2` ← `data_in`; go to S_OP.
- S_OP, on `enter_p`: `op_select` ← `op_in`; go to S_EXEC.
- S_EXEC: unconditional single cycle that lets the combinational ALU settle. On exit:
  - `result_q` ← `resultado_in`, `result_valid` ← 1, `err` ← 0; go to S_SHOW.
  - Exception: if `op_select` is 0011 or 0100 and `operand2` is 0, or `op_select` > 1001, then `result_q` ← 0 and `err` ← 1.
- S_SHOW: all outputs hold. On `enter_p`, go to S_A; `operand1`, `operand2`, `op_select` and `result_q` keep their values until overwritten.
- `clear`, in any state: go to S_A; `operand1`, `operand2`, `op_select` and `result_q` ← 0; `result_valid` and `err` ← 0.
- `clear` and `enter_p` in the same cycle: `clear` wins and the enter pulse is discarded.
- An `enter_p` arriving while in S_EXEC is ignored.

## Timing
- Reset values: all outputs 0; state S_A (`state_code` 0); synchronizer and edge flops 0.
- Reset asserted mid-operation aborts immediately and asynchronously to the values above. There is no partial capture.
- Enter latency: `enter` first sampled high at edge k gives `enter_p` high during the cycle after edge k+2. The resulting capture and state change are visible after edge k+3.
- Execute latency: S_OP→S_EXEC at edge t; `result_q`/`result_valid` update at edge t+1.
- Clear latency: a `clear` sampled at edge t takes effect at edge t.
- Arithmetic: no width conversion is done in this block. `result_q` is a bit-exact copy of `resultado_in`, and SUB underflow arrives already wrapped to 2·Nbits from the calculator.
- Capture rule: `data_in` is captured at the edge where `enter_p` is acted on, not where `enter` was first seen. Switches must therefore be stable for at least 4 cycles after the press.

## Structure
- Shared package `calc_pkg`:
  - `op_t` enum holding the ten operation codes.
  - `OP_LAST` = 4'b1001.
  - `seq_state_t` enum for the five states.
  - The `Nbits`-independent constants.
- One sub-module, `enter_sync_edge` (two-flop synchronizer plus rising-edge pulse), with `clock`/`reset_n`. It is reused later for other buttons.
- The FSM and datapath registers live in `calc_operand_sequencer`. The bench instantiates it together with the calculator (Nbits=4).

## Test plan
- Reset with `enter` held high, then release `reset_n`: all outputs 0 and state 0, and no capture occurs until `enter` drops and rises again.
- Enter 0101, 0011, op 0000: `result_q`=00001000, `result_valid`=1, `err`=0, `state_code`=4. Holding `enter` for 20 cycles on each press produces one action per press.
- Enter 1111, 0011, op 0010: `result_q`=00101101. Then enter 0011, 0101, op 0001: `result_q`=11111110 (wrapped).
- Enter 1110, 0000, op 0011: `result_q`=0, `err`=1. Then op 1100 with nonzero operands: `err`=1. `result_valid`=1 in both cases.
- Assert `clear` in S_OP coincident with `enter_p`: next state S_A, operands, op and result 0. Then assert `reset_n`=0 mid-S_EXEC: outputs 0 immediately, without waiting for a clock edge.
- Back-to-back runs: 1110 SHR 0010 gives 00000011, then `enter` in S_SHOW, then 1011 AND 0011 gives 00000011. `result_valid` drops to 0 at the S_A capture.
